// File: rtl/aes_pkg.sv
// Shared AES column types and GF(2^8) helpers for the MixColumns datapath.
package aes_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned COL_W          = 32;
  localparam int unsigned COLS_PER_STATE = 4;
  localparam logic [7:0]  AES_POLY       = 8'h1B;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [COL_W-1:0]  col_t;

  // Per-column xtime ladder; index is the AES byte number (b0..b3), not bit position.
  typedef struct packed {
    byte_t [3:0] x8;
    byte_t [3:0] x4;
    byte_t [3:0] x2;
    byte_t [3:0] x1;
  } col_prod_t;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic int unsigned beats_per_state(input int unsigned ncol);
    return COLS_PER_STATE / ncol;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// One-column MixColumns/InvMixColumns: product half (xtime ladder) and combine half (XOR).
module mix_column_unit
  import aes_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  col_t      col,
  output col_prod_t prod_c,
  input  col_prod_t prod,
  input  logic      inv,
  output col_t      mixed_c
);

  // x4/x8 only feed the inverse coefficients, so they stay zero without inverse support
  always_comb begin
    prod_c = '0;
    for (int i = 0; i < 4; i++) begin
      prod_c.x1[i] = col[BYTE_W*(3-i) +: BYTE_W];
      prod_c.x2[i] = xtime(prod_c.x1[i]);
      if (INV_EN) begin
        prod_c.x4[i] = xtime(prod_c.x2[i]);
        prod_c.x8[i] = xtime(prod_c.x4[i]);
      end
    end
  end

  // Output byte j: coefficients {2,3,1,1} or {e,b,d,9} on bytes j, j+1, j+2, j+3 (mod 4)
  always_comb begin
    mixed_c = '0;
    for (int j = 0; j < 4; j++) begin
      mixed_c[BYTE_W*(3-j) +: BYTE_W] = inv ?
        ((prod.x8[j]       ^ prod.x4[j]       ^ prod.x2[j])       ^
         (prod.x8[(j+1)%4] ^ prod.x2[(j+1)%4] ^ prod.x1[(j+1)%4]) ^
         (prod.x8[(j+2)%4] ^ prod.x4[(j+2)%4] ^ prod.x1[(j+2)%4]) ^
         (prod.x8[(j+3)%4] ^ prod.x1[(j+3)%4])) :
        (prod.x2[j] ^
         (prod.x2[(j+1)%4] ^ prod.x1[(j+1)%4]) ^
         prod.x1[(j+2)%4] ^
         prod.x1[(j+3)%4]);
    end
  end

endmodule

// File: rtl/mix_columns_pipe.sv
// Pipelined NCOL-column MixColumns/InvMixColumns engine with valid/ready flow control.
module mix_columns_pipe
  import aes_pkg::*;
#(
  parameter int unsigned NCOL        = 4,
  parameter int unsigned PIPE_STAGES = 2,
  parameter bit          INV_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [COL_W*NCOL-1:0] i_Data,
  input  logic                  i_Inv,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  output logic [COL_W*NCOL-1:0] o_Data,
  output logic                  o_Last
);

  localparam int unsigned DATA_W          = COL_W * NCOL;
  localparam int unsigned BEATS_PER_STATE = beats_per_state(NCOL);
  localparam int unsigned CNT_W           = (BEATS_PER_STATE > 1) ? $clog2(BEATS_PER_STATE) : 1;

  col_prod_t          prod_c    [NCOL];
  col_prod_t          comb_prod [NCOL];
  col_t               mixed_c   [NCOL];
  logic [DATA_W-1:0]  mixed_data_c;
  logic               beat_inv_c;
  logic               comb_inv;
  logic               comb_valid;
  logic               out_adv;
  logic               out_fire;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   beat_idx;

  assign beat_inv_c = INV_EN & i_Inv;

  // Column 0 occupies the MSBs of the beat
  for (genvar c = 0; c < NCOL; c++) begin : g_col
    mix_column_unit #(.INV_EN(INV_EN)) u_col (
      .col     (i_Data[DATA_W-1-COL_W*c -: COL_W]),
      .prod_c  (prod_c[c]),
      .prod    (comb_prod[c]),
      .inv     (comb_inv),
      .mixed_c (mixed_c[c])
    );
    assign mixed_data_c[DATA_W-1-COL_W*c -: COL_W] = mixed_c[c];
  end

  if (PIPE_STAGES == 2) begin : g_two_stage
    logic      s1_valid;
    logic      s1_inv;
    logic      s1_en;
    col_prod_t s1_prod [NCOL];

    assign s1_en   = !s1_valid | out_adv;
    assign o_Ready = s1_en;

    // Stage 1 holds the xtime ladder and the beat's mode
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_inv   <= 1'b0;
        for (int c = 0; c < NCOL; c++) s1_prod[c] <= '0;
      end else if (s1_en) begin
        s1_valid <= i_Valid;
        if (i_Valid) begin
          s1_inv <= beat_inv_c;
          for (int c = 0; c < NCOL; c++) s1_prod[c] <= prod_c[c];
        end
      end
    end

    always_comb begin
      comb_valid = s1_valid;
      comb_inv   = s1_inv;
      for (int c = 0; c < NCOL; c++) comb_prod[c] = s1_prod[c];
    end
  end else begin : g_one_stage
    assign o_Ready = out_adv;

    always_comb begin
      comb_valid = i_Valid;
      comb_inv   = beat_inv_c;
      for (int c = 0; c < NCOL; c++) comb_prod[c] = prod_c[c];
    end
  end

  assign out_adv  = !o_Valid | i_Ready;
  assign out_fire = o_Valid & i_Ready;
  assign cnt_inc  = (beat_cnt == CNT_W'(BEATS_PER_STATE - 1)) ? '0 : beat_cnt + CNT_W'(1);
  // Index of a beat entering the output stage: the current one is leaving if it fires
  assign beat_idx = out_fire ? cnt_inc : beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_Valid  <= 1'b0;
      o_Last   <= 1'b0;
      o_Data   <= '0;
      beat_cnt <= '0;
    end else begin
      if (out_fire) beat_cnt <= cnt_inc;
      if (out_adv) begin
        o_Valid <= comb_valid;
        o_Last  <= comb_valid & (beat_idx == CNT_W'(BEATS_PER_STATE - 1));
        if (comb_valid) o_Data <= mixed_data_c;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns_pipe.sv
// Directed bench: NCOL=4 two-stage engine and NCOL=1 single-stage engine against known AES columns.
module tb_mix_columns_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;

  logic         in_valid4 = 1'b0, out_ready4, inv4 = 1'b0, out_valid4, ds_ready4 = 1'b1, out_last4;
  logic [127:0] in_data4 = '0, out_data4;
  logic         in_valid1 = 1'b0, out_ready1, inv1 = 1'b0, out_valid1, ds_ready1 = 1'b1, out_last1;
  logic [31:0]  in_data1 = '0, out_data1;

  int applied = 0;
  int miscompares = 0;

  logic [31:0] col_in  [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101,
                               32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
  logic [31:0] col_out [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
                               32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};
  logic [31:0] n1_in  [5] = '{32'hd4d4d4d5, 32'h2d26314c, 32'hdb135345, 32'h01010101, 32'hd4d4d4d5};
  logic [31:0] n1_exp [5] = '{32'hd5d5d7d6, 32'h4d7ebdf8, 32'h8e4da1bc, 32'h01010101, 32'hd5d5d7d6};

  mix_columns_pipe #(.NCOL(4), .PIPE_STAGES(2), .INV_EN(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_Valid(in_valid4), .o_Ready(out_ready4), .i_Data(in_data4),
    .i_Inv(inv4), .o_Valid(out_valid4), .i_Ready(ds_ready4), .o_Data(out_data4), .o_Last(out_last4)
  );

  mix_columns_pipe #(.NCOL(1), .PIPE_STAGES(1), .INV_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_Valid(in_valid1), .o_Ready(out_ready1), .i_Data(in_data1),
    .i_Inv(inv1), .o_Valid(out_valid1), .i_Ready(ds_ready1), .o_Data(out_data1), .o_Last(out_last1)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    applied++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL reset_valid4: got %b want 0", out_valid4); end
    applied++; if (out_last4 !== 1'b0) begin miscompares++; $display("FAIL reset_last4: got %b want 0", out_last4); end
    applied++; if (out_data4 !== 128'h0) begin miscompares++; $display("FAIL reset_data4: got %h want 0", out_data4); end
    applied++; if (out_ready4 !== 1'b1) begin miscompares++; $display("FAIL reset_ready4: got %b want 1", out_ready4); end
    applied++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid1: got %b want 0", out_valid1); end
    applied++; if (out_ready1 !== 1'b1) begin miscompares++; $display("FAIL reset_ready1: got %b want 1", out_ready1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fwd();
    @(negedge clk);
    in_valid4 = 1'b1; inv4 = 1'b0;
    in_data4  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    #1;
    applied++; if (out_ready4 !== 1'b1) begin miscompares++; $display("FAIL fwd_ready: got %b want 1", out_ready4); end
    @(negedge clk);
    in_valid4 = 1'b0;
    #1;
    applied++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL fwd_latency_early: valid %b want 0", out_valid4); end
    @(negedge clk);
    #1;
    applied++; if (out_valid4 !== 1'b1) begin miscompares++; $display("FAIL fwd_latency: valid %b want 1", out_valid4); end
    applied++; if (out_data4 !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
      miscompares++; $display("FAIL fwd_data: got %h want 8e4da1bc9fdc589d01010101c6c6c6c6", out_data4); end
    applied++; if (out_last4 !== 1'b1) begin miscompares++; $display("FAIL fwd_last: got %b want 1", out_last4); end
    @(negedge clk);
    #1;
    applied++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL fwd_dup: valid %b want 0", out_valid4); end
  endtask

  task automatic test_inv();
    @(negedge clk);
    in_valid4 = 1'b1; inv4 = 1'b1;
    in_data4  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    @(negedge clk);
    in_valid4 = 1'b0; inv4 = 1'b0;
    @(negedge clk);
    #1;
    applied++; if (out_valid4 !== 1'b1) begin miscompares++; $display("FAIL inv_latency: valid %b want 1", out_valid4); end
    applied++; if (out_data4 !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
      miscompares++; $display("FAIL inv_data: got %h want db135345f20a225c01010101c6c6c6c6", out_data4); end
    applied++; if (out_last4 !== 1'b1) begin miscompares++; $display("FAIL inv_last: got %b want 1", out_last4); end
  endtask

  task automatic test_ncol1();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid1 = (k < 5);
      in_data1  = (k < 5) ? n1_in[k] : 32'h0;
      inv1      = 1'b0;
      #1;
      if (k > 0) begin
        applied++; if (out_valid1 !== 1'b1) begin miscompares++; $display("FAIL ncol1_valid[%0d]: got %b want 1", k-1, out_valid1); end
        applied++; if (out_data1 !== n1_exp[k-1]) begin miscompares++; $display("FAIL ncol1_data[%0d]: got %h want %h", k-1, out_data1, n1_exp[k-1]); end
        applied++; if (out_last1 !== (k-1 == 3)) begin miscompares++; $display("FAIL ncol1_last[%0d]: got %b want %b", k-1, out_last1, (k-1 == 3)); end
      end
    end
    in_valid1 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] bp_in [6];
    logic [127:0] bp_exp [6];
    int tx, rx, first_rx, last_rx;
    for (int k = 0; k < 6; k++) begin
      bp_in[k]  = {col_in[k%6], col_in[(k+1)%6], col_in[(k+2)%6], col_in[(k+3)%6]};
      bp_exp[k] = {col_out[k%6], col_out[(k+1)%6], col_out[(k+2)%6], col_out[(k+3)%6]};
    end
    tx = 0; rx = 0; first_rx = -1; last_rx = -1;
    for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
      @(negedge clk);
      ds_ready4 = (cyc >= 5);
      in_valid4 = (tx < 6);
      in_data4  = bp_in[(tx < 6) ? tx : 0];
      inv4      = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        applied++; if (out_data4 !== bp_exp[0] || out_valid4 !== 1'b1) begin
          miscompares++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", cyc, out_valid4, out_data4, bp_exp[0]); end
      end
      if (cyc == 4) begin
        applied++; if (out_ready4 !== 1'b0) begin miscompares++; $display("FAIL bp_ready_drop: got %b want 0", out_ready4); end
        applied++; if (tx !== 2) begin miscompares++; $display("FAIL bp_accepted: got %0d want 2", tx); end
      end
      if (out_valid4 && ds_ready4) begin
        applied++; if (out_data4 !== bp_exp[rx] || out_last4 !== 1'b1) begin
          miscompares++; $display("FAIL bp_order[%0d]: got %h last=%b want %h last=1", rx, out_data4, out_last4, bp_exp[rx]); end
        if (first_rx < 0) first_rx = cyc;
        last_rx = cyc;
        rx++;
      end
      if (in_valid4 && out_ready4) tx++;
    end
    in_valid4 = 1'b0; ds_ready4 = 1'b1;
    applied++; if (rx !== 6) begin miscompares++; $display("FAIL bp_count: got %0d want 6", rx); end
    applied++; if (first_rx !== 5 || last_rx !== 10) begin
      miscompares++; $display("FAIL bp_rate: first %0d last %0d want 5 10", first_rx, last_rx); end
  endtask

  task automatic test_mixed_mode();
    logic [127:0] fwd_beat, inv_beat;
    int tx, rx;
    fwd_beat = {32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c};
    inv_beat = {32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8};
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 20 && rx < 6; cyc++) begin
      @(negedge clk);
      in_valid4 = (tx < 6);
      inv4      = (tx % 2 == 1);
      in_data4  = (tx % 2 == 1) ? inv_beat : fwd_beat;
      #1;
      if (out_valid4) begin
        applied++; if (out_data4 !== ((rx % 2 == 1) ? fwd_beat : inv_beat)) begin
          miscompares++; $display("FAIL mixed[%0d]: got %h want %h", rx, out_data4, (rx % 2 == 1) ? fwd_beat : inv_beat); end
        rx++;
      end
      if (in_valid4 && out_ready4) tx++;
    end
    in_valid4 = 1'b0; inv4 = 1'b0;
    applied++; if (rx !== 6) begin miscompares++; $display("FAIL mixed_count: got %0d want 6", rx); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid4 = 1'b1; in_data4 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    in_valid1 = 1'b1; in_data1 = 32'hd4d4d4d5; ds_ready1 = 1'b0;
    @(negedge clk);
    in_data4 = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
    @(negedge clk);
    in_valid4 = 1'b0; in_valid1 = 1'b0;
    #1;
    applied++; if (out_valid4 !== 1'b1 || out_valid1 !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_inflight: v4=%b v1=%b want 1 1", out_valid4, out_valid1); end
    rst_n = 1'b0;
    #1;
    applied++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid4: got %b want 0", out_valid4); end
    applied++; if (out_last4 !== 1'b0) begin miscompares++; $display("FAIL rstmid_last4: got %b want 0", out_last4); end
    applied++; if (out_data4 !== 128'h0) begin miscompares++; $display("FAIL rstmid_data4: got %h want 0", out_data4); end
    applied++; if (out_ready4 !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready4: got %b want 1", out_ready4); end
    applied++; if (out_valid1 !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid1: got %b want 0", out_valid1); end
    @(negedge clk);
    rst_n = 1'b1; ds_ready1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      applied++; if (out_valid4 !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale[%0d]: valid %b want 0", k, out_valid4); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid1 = (k < 4);
      in_data1  = (k < 4) ? n1_in[k] : 32'h0;
      #1;
      if (k > 0) begin
        applied++; if (out_valid1 !== 1'b1 || out_data1 !== n1_exp[k-1] || out_last1 !== (k-1 == 3)) begin
          miscompares++; $display("FAIL rstmid_restart[%0d]: got v=%b %h last=%b want v=1 %h last=%b",
                                  k-1, out_valid1, out_data1, out_last1, n1_exp[k-1], (k-1 == 3)); end
      end
    end
    in_valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_inv();
    test_ncol1();
    test_backpressure();
    test_mixed_mode();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
